// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and the data port, sequencing MAR/MDR/write-enable.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; the default build uses fixed data-over-fetch priority.
module mem_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       fReq,
   input  logic       dReq,
   input  logic       dWE,
   output logic [1:0] busSel,
   output logic       ldMAR,
   output logic       ldMDR,
   output logic       selMDR,
   output logic       memWE,
   output logic       fAck,
   output logic       dAck,
   output logic       busy
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ADDR = 3'd1;
   localparam logic [2:0] RD   = 3'd2;
   localparam logic [2:0] WDAT = 3'd3;
   localparam logic [2:0] WR   = 3'd4;
   localparam logic [2:0] DONE = 3'd5;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       win_data;
   logic       win_we;
   logic       grant_data;
   logic       any_req;

   assign any_req = fReq | dReq;

`ifdef MEM_ARBITER_RR_EN
   // prio_data=1 means the data port wins a tie; it points away from the last grant.
   logic prio_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_data <= 1'b1;
      end else if (state == IDLE && any_req) begin
         prio_data <= ~grant_data;
      end
   end

   assign grant_data = dReq & (~fReq | prio_data);
`else
   assign grant_data = dReq;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ADDR;
         ADDR:    state_nxt = win_we ? WDAT : RD;
         RD:      state_nxt = DONE;
         WDAT:    state_nxt = WR;
         WR:      state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Winner and direction are frozen at grant so later input changes cannot alter the transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         win_data <= 1'b1;
         win_we   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_req) begin
            win_data <= grant_data;
            win_we   <= grant_data & dWE;
         end
      end
   end

   always_comb begin
      busSel = 2'd0;
      ldMAR  = 1'b0;
      ldMDR  = 1'b0;
      selMDR = 1'b0;
      memWE  = 1'b0;
      fAck   = 1'b0;
      dAck   = 1'b0;
      busy   = (state != IDLE);
      case (state)
         ADDR: begin
            busSel = win_data ? 2'd2 : 2'd1;
            ldMAR  = 1'b1;
         end
         RD: begin
            ldMDR  = 1'b1;
            selMDR = 1'b1;
         end
         WDAT: begin
            busSel = 2'd3;
            ldMDR  = 1'b1;
         end
         WR: begin
            memWE = 1'b1;
         end
         DONE: begin
            fAck = ~win_data;
            dAck = win_data;
         end
         default: ;
      endcase
   end

endmodule
